// File: rtl/seq_uart_tx.sv
// UART transmitter that drains a pull-style word source (get/in/empty).
// It sends one frame per word: a start bit, then W data bits LSB first, then STOP stop bits.
module seq_uart_tx #(
  parameter int W    = 8,
  parameter int DIV  = 16,
  parameter int STOP = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] in,
  output logic         get,
  input  logic         empty,
  input  logic         run,
  output logic         tx,
  output logic         busy,
  output logic         sent
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(W + 1);

  if (DIV < 2) begin : g_bad_div
    $error("seq_uart_tx: DIV must be >= 2");
  end
  if (STOP < 1 || STOP > 2) begin : g_bad_stop
    $error("seq_uart_tx: STOP must be 1 or 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

  state_t          state, state_n;
  logic [DW-1:0]   div, div_n;
  logic [BW-1:0]   bcnt, bcnt_n;
  logic [W-1:0]    shift, shift_n;
  logic            tx_n;
  logic            div_end;

  assign div_end = (div == DW'(DIV - 1));
  assign get     = (state == S_IDLE) & run & ~empty & ~reset;
  assign busy    = (state != S_IDLE);
  // In the stop phase, the bit counter is reused to count the stop bits.
  assign sent    = (state == S_STOP) & div_end & (bcnt == BW'(STOP - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      div   <= '0;
      bcnt  <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      div   <= div_n;
      bcnt  <= bcnt_n;
      shift <= shift_n;
      tx    <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div;
    bcnt_n  = bcnt;
    shift_n = shift;
    tx_n    = tx;
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (get) state_n = S_LOAD;
      end
      S_LOAD: begin
        shift_n = in;
        div_n   = '0;
        bcnt_n  = '0;
        tx_n    = 1'b0;
        state_n = S_START;
      end
      S_START: begin
        if (div_end) begin
          div_n   = '0;
          tx_n    = shift[0];
          state_n = S_DATA;
        end else begin
          div_n = div + DW'(1);
        end
      end
      S_DATA: begin
        if (div_end) begin
          div_n = '0;
          if (bcnt == BW'(W - 1)) begin
            bcnt_n  = '0;
            tx_n    = 1'b1;
            state_n = S_STOP;
          end else begin
            shift_n = shift >> 1;
            bcnt_n  = bcnt + BW'(1);
            tx_n    = shift_n[0];
          end
        end else begin
          div_n = div + DW'(1);
        end
      end
      S_STOP: begin
        tx_n = 1'b1;
        if (div_end) begin
          div_n = '0;
          if (bcnt == BW'(STOP - 1)) begin
            bcnt_n  = '0;
            state_n = S_IDLE;
          end else begin
            bcnt_n = bcnt + BW'(1);
          end
        end else begin
          div_n = div + DW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_uart_tx.sv
// Directed bench for seq_uart_tx: instance a (W=8, DIV=4, STOP=1) and instance b (W=8, DIV=3, STOP=2),
// each fed by a small pull-style source model.
module tb_seq_uart_tx;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // instance a and its source
  logic       reset_a, run_a, get_a, tx_a, busy_a, sent_a, empty_a, src_rst_a;
  logic [7:0] in_a;
  logic [7:0] mem_a [0:7];
  int         ptr_a = 0, n_a = 0;
  assign empty_a = (ptr_a >= n_a);

  always @(posedge clock) begin
    if (src_rst_a) ptr_a <= 0;
    else if (get_a) begin
      in_a  <= mem_a[ptr_a[2:0]];
      ptr_a <= ptr_a + 1;
    end
  end

  // instance b and its source
  logic       reset_b, run_b, get_b, tx_b, busy_b, sent_b, empty_b;
  logic [7:0] in_b, word_b;
  int         ptr_b = 0, n_b = 0;
  assign empty_b = (ptr_b >= n_b);

  always @(posedge clock) begin
    if (get_b) begin
      in_b  <= word_b;
      ptr_b <= ptr_b + 1;
    end
  end

  seq_uart_tx #(.W(8), .DIV(4), .STOP(1)) dut_a (
    .clock(clock), .reset(reset_a), .in(in_a), .get(get_a), .empty(empty_a),
    .run(run_a), .tx(tx_a), .busy(busy_a), .sent(sent_a)
  );

  seq_uart_tx #(.W(8), .DIV(3), .STOP(2)) dut_b (
    .clock(clock), .reset(reset_b), .in(in_b), .get(get_b), .empty(empty_b),
    .run(run_b), .tx(tx_b), .busy(busy_b), .sent(sent_b)
  );

  int cyc = 0, gets_a = 0, sents_a = 0, gets_b = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (get_a)  gets_a  <= gets_a + 1;
    if (sent_a) sents_a <= sents_a + 1;
    if (get_b)  gets_b  <= gets_b + 1;
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  // Wait for the start bit, then compare 40 cycles of tx/sent/busy against the hand-written line.
  task automatic check_frame(input logic [9:0] line, input string tag, output int st);
    int w;
    logic [39:0] a_tx, e_tx, a_sent, a_busy;
    w = 0;
    tick();
    while (tx_a !== 1'b0 && w < 200) begin
      tick();
      w++;
    end
    chk({tag, "_start_seen"}, tx_a, 1'b0);
    st = cyc;
    a_tx = '0; e_tx = '0; a_sent = '0; a_busy = '0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) tick();
      a_tx   = {a_tx[38:0], tx_a};
      e_tx   = {e_tx[38:0], line[9 - k/4]};
      a_sent = {a_sent[38:0], sent_a};
      a_busy = {a_busy[38:0], busy_a};
    end
    chk({tag, "_tx"}, a_tx, e_tx);
    chk({tag, "_sent"}, a_sent, 40'd1);
    chk({tag, "_busy"}, a_busy, {40{1'b1}});
  endtask

  task automatic src_load_a;
    n_a = 0;
    src_rst_a = 1'b1;
    tick();
    src_rst_a = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // start, d0..d7, stop in time order
  } vec_t;

  vec_t t1 [3];
  vec_t t4 [3];

  initial begin
    int st, prev, g0, s0, bad_get, bad_tx, bad_busy, w;
    logic [32:0] b_tx, b_sent, b_busy;

    t1[0] = '{8'h55, 10'b0101010101};
    t1[1] = '{8'hA3, 10'b0110001011};
    t1[2] = '{8'h00, 10'b0000000001};
    t4[0] = '{8'h5A, 10'b0010110101};
    t4[1] = '{8'h0F, 10'b0111100001};
    t4[2] = '{8'hC1, 10'b0100000111};

    reset_a = 1'b1; run_a = 1'b0; src_rst_a = 1'b1;
    reset_b = 1'b1; run_b = 1'b0; word_b = 8'hFF;
    tick(); tick(); tick();
    chk("rst_tx", tx_a, 1'b1);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_sent", sent_a, 1'b0);
    chk("rst_get", get_a, 1'b0);
    src_rst_a = 1'b0;
    reset_a = 1'b0; reset_b = 1'b0;
    run_a = 1'b1; run_b = 1'b1;

    // empty source with run high
    bad_get = 0; bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (get_a !== 1'b0) bad_get++;
      if (tx_a !== 1'b1) bad_tx++;
      if (busy_a !== 1'b0) bad_busy++;
    end
    chk("t2_get_cycles", bad_get, 0);
    chk("t2_tx_cycles", bad_tx, 0);
    chk("t2_busy_cycles", bad_busy, 0);

    // three back-to-back frames
    for (int i = 0; i < 3; i++) mem_a[i] = t1[i].data;
    src_load_a();
    g0 = gets_a; s0 = sents_a;
    n_a = 3;
    prev = 0;
    for (int i = 0; i < 3; i++) begin
      check_frame(t1[i].line, $sformatf("t1_f%0d", i), st);
      if (i > 0) chk($sformatf("t1_period%0d", i), st - prev, 42);
      prev = st;
    end
    repeat (5) tick();
    chk("t1_gets", gets_a - g0, 3);
    chk("t1_sents", sents_a - s0, 3);
    chk("t1_idle_busy", busy_a, 1'b0);
    chk("t1_idle_tx", tx_a, 1'b1);

    // run low from reset, then raise run
    reset_a = 1'b1; run_a = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) mem_a[i] = t4[i].data;
    src_load_a();
    n_a = 3;
    reset_a = 1'b0;
    bad_get = 0; bad_busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (get_a !== 1'b0) bad_get++;
      if (busy_a !== 1'b0) bad_busy++;
    end
    chk("t3_no_get", bad_get, 0);
    chk("t3_no_busy", bad_busy, 0);
    g0 = gets_a; s0 = sents_a;
    run_a = 1'b1;
    #1 chk("t3_get_same_cycle", get_a, 1'b1);
    tick();
    chk("t3_load_tx", tx_a, 1'b1);
    tick();
    chk("t3_start_low", tx_a, 1'b0);

    // drop run during the data phase of frame 1
    repeat (8) tick();
    chk("t4_in_frame", busy_a, 1'b1);
    run_a = 1'b0;
    w = 0;
    tick();
    while (sent_a !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    chk("t4_sent_seen", sent_a, 1'b1);
    bad_get = 0; bad_busy = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (get_a !== 1'b0) bad_get++;
      if (busy_a !== 1'b0) bad_busy++;
    end
    chk("t4_paused_get", bad_get, 0);
    chk("t4_paused_busy", bad_busy, 0);
    chk("t4_gets_paused", gets_a - g0, 1);
    chk("t4_sents_paused", sents_a - s0, 1);
    run_a = 1'b1;
    check_frame(t4[1].line, "t4_f1", st);
    check_frame(t4[2].line, "t4_f2", st);
    tick();
    chk("t4_gets_total", gets_a - g0, 3);

    // reset during data bit 4
    mem_a[0] = 8'hC3; mem_a[1] = 8'h81;
    src_load_a();
    n_a = 2;
    repeat (23) tick();
    chk("t5_bit4_tx", tx_a, 1'b0);
    s0 = sents_a;
    reset_a = 1'b1;
    #1 chk("t5_get_in_reset", get_a, 1'b0);
    tick();
    chk("t5_tx_after_reset", tx_a, 1'b1);
    chk("t5_busy_after_reset", busy_a, 1'b0);
    reset_a = 1'b0;
    #1 chk("t5_get_after_reset", get_a, 1'b1);
    check_frame(10'b0100000011, "t5_f", st);
    tick();
    chk("t5_sents", sents_a - s0, 1);

    // DIV=3, STOP=2, byte 0xFF
    n_b = 1;
    #1 chk("t6_get", get_b, 1'b1);
    tick();
    chk("t6_load_tx", tx_b, 1'b1);
    b_tx = '0; b_sent = '0; b_busy = '0;
    for (int k = 0; k < 33; k++) begin
      tick();
      b_tx   = {b_tx[31:0], tx_b};
      b_sent = {b_sent[31:0], sent_b};
      b_busy = {b_busy[31:0], busy_b};
    end
    chk("t6_tx", b_tx, {3'b000, {30{1'b1}}});
    chk("t6_sent", b_sent, 33'd1);
    chk("t6_busy", b_busy, {33{1'b1}});
    tick();
    chk("t6_idle_busy", busy_b, 1'b0);
    chk("t6_idle_tx", tx_b, 1'b1);
    chk("t6_idle_get", get_b, 1'b0);
    chk("t6_gets", gets_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
